// File: rtl/geo_sort_ctrl.sv
// Angular bubble-sort of points 1..N_PT-1 CCW around anchor point 0, driving an external cross-product unit.
// Optional GEO_SORT_EARLY_EXIT_EN: finish after the first pass that performs no swap.
module geo_sort_ctrl #(
  parameter int N_PT = 6,
  parameter int W    = 10,
  localparam int IW  = $clog2(N_PT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_vld,
  output logic                load_rdy,
  input  logic [W-1:0]        load_x,
  input  logic [W-1:0]        load_y,
  output logic                busy,
  output logic                done,
  output logic                sorted_vld,
  input  logic [IW-1:0]       rd_idx,
  output logic [W-1:0]        rd_x,
  output logic [W-1:0]        rd_y,
  output logic                cp_start,
  output logic signed [W:0]   cp_Ax,
  output logic signed [W:0]   cp_Ay,
  output logic signed [W:0]   cp_Bx,
  output logic signed [W:0]   cp_By,
  input  logic                cp_cmp,
  input  logic                cp_a_bigger
);

  typedef enum logic [2:0] {IDLE, LOAD, PREP, ISSUE, WB, DONE} state_t;

  localparam logic [IW-1:0] LAST_BEAT = IW'(N_PT - 1);
  localparam logic [IW-1:0] P_LAST    = IW'(N_PT - 3);

  state_t        state, state_nxt;
  logic [W-1:0]  px [N_PT];
  logic [W-1:0]  py [N_PT];
  logic [IW-1:0] load_cnt, j, p, j_last, j1;
  logic          abig_q, sorted_q;
`ifdef GEO_SORT_EARLY_EXIT_EN
  logic          pass_swp;
`endif

  assign j_last     = IW'(N_PT - 2) - p;
  assign j1         = j + IW'(1);
  assign load_rdy   = (state == IDLE) || (state == LOAD);
  assign busy       = (state == PREP) || (state == ISSUE) || (state == WB) || (state == DONE);
  assign done       = (state == DONE);
  assign cp_start   = (state == ISSUE);
  assign sorted_vld = sorted_q;
  assign rd_x       = px[rd_idx];
  assign rd_y       = py[rd_idx];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, LOAD: begin
        if (load_vld && load_cnt == LAST_BEAT) state_nxt = PREP;
        else if (load_vld)                     state_nxt = LOAD;
      end
      PREP:  state_nxt = ISSUE;
      ISSUE: if (cp_cmp) state_nxt = WB;
      WB: begin
        if (j != j_last)      state_nxt = PREP;
        else if (p == P_LAST) state_nxt = DONE;
`ifdef GEO_SORT_EARLY_EXIT_EN
        else if (!(pass_swp || abig_q)) state_nxt = DONE;
`endif
        else                  state_nxt = PREP;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      load_cnt <= '0;
      j        <= IW'(1);
      p        <= '0;
      abig_q   <= 1'b0;
      sorted_q <= 1'b0;
      cp_Ax    <= '0;
      cp_Ay    <= '0;
      cp_Bx    <= '0;
      cp_By    <= '0;
`ifdef GEO_SORT_EARLY_EXIT_EN
      pass_swp <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, LOAD: begin
          if (load_vld) begin
            if (load_cnt == '0) sorted_q <= 1'b0;
            if (load_cnt == LAST_BEAT) begin
              load_cnt <= '0;
              j        <= IW'(1);
              p        <= '0;
`ifdef GEO_SORT_EARLY_EXIT_EN
              pass_swp <= 1'b0;
`endif
            end else begin
              load_cnt <= load_cnt + IW'(1);
            end
          end
        end
        // Zero-extended differences cannot overflow W+1 signed bits.
        PREP: begin
          cp_Ax <= {1'b0, px[j]}  - {1'b0, px[0]};
          cp_Ay <= {1'b0, py[j]}  - {1'b0, py[0]};
          cp_Bx <= {1'b0, px[j1]} - {1'b0, px[0]};
          cp_By <= {1'b0, py[j1]} - {1'b0, py[0]};
        end
        ISSUE: if (cp_cmp) abig_q <= cp_a_bigger;
        WB: begin
          if (state_nxt == DONE) sorted_q <= 1'b1;
          if (j == j_last) begin
            j <= IW'(1);
            p <= p + IW'(1);
          end else begin
            j <= j1;
          end
`ifdef GEO_SORT_EARLY_EXIT_EN
          if (j == j_last) pass_swp <= 1'b0;
          else if (abig_q) pass_swp <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  // Register file is not reset; contents only matter once sorted_vld is set.
  always_ff @(posedge clk) begin
    if (load_rdy && load_vld) begin
      px[load_cnt] <= load_x;
      py[load_cnt] <= load_y;
    end else if (state == WB && abig_q) begin
      px[j]  <= px[j1];
      py[j]  <= py[j1];
      px[j1] <= px[j];
      py[j1] <= py[j];
    end
  end

endmodule

// File: doc/geo_sort_ctrl.md
# geo_sort_ctrl

Angular-sort controller for the geofence datapath. Captures N_PT receiver points, holds point 0 as the anchor, and bubble-sorts points 1..N_PT-1 counter-clockwise around it. It sequences the shared 2-cycle-multiplier cross-product unit over the start/cmp/result handshake and swaps register-file entries based on each result. The sorted set is then read by the downstream inside/outside test.

## Interface
- N_PT, 6, number of points per set, including the anchor (≥3)
- W, 10, unsigned coordinate width; difference width is W+1 signed
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- load_vld  in  1  point beat valid
- load_rdy  out  1  high in IDLE; beat accepted when load_vld & load_rdy
- load_x, load_y  in  W  point coordinates, loaded in index order 0..N_PT-1
- busy  out  1  high from acceptance of the last beat until DONE exits
- done  out  1  one-cycle pulse when the sort completes
- sorted_vld  out  1  register-file contents are sorted; set with done, cleared on first beat of next set
- rd_idx  in  ceil(log2 N_PT)  read index
- rd_x, rd_y  out  W  combinational read of entry rd_idx
- cp_start  out  1  held high for the duration of one comparison (start_flg)
- cp_Ax, cp_Ay, cp_Bx, cp_By  out  W+1 signed  operand vectors, stable while cp_start is high
- cp_cmp  in  1  comparison complete (cmp_flg)
- cp_a_bigger  in  1  result, valid when cp_cmp is high: (Bx·Ay − Ax·By) ≥ 0

## Operation
- States: IDLE, LOAD, PREP, ISSUE, WB, DONE.
- IDLE/LOAD: a load counter writes beat k to entry k. Beats are accepted only in IDLE/LOAD. After beat N_PT-1, go to PREP and set busy.
- Loop: pass p = 0..N_PT-3. Inner j = 1..N_PT-2-p. Total comparisons C = (N_PT-1)(N_PT-2)/2, which is 10 for N_PT=6.
- PREP: register A = P[j]−P0 and B = P[j+1]−P0, each component as zero-extended (W+1)-bit subtraction. No overflow for unsigned W-bit inputs.
- ISSUE: drive cp_start=1 with operands held. Stay in ISSUE until cp_cmp=1 is sampled, latching cp_a_bigger in that cycle.
- WB: drive cp_start=0. This cycle is mandatory so the unit's internal timer clears. If the latched bit is 1, swap entries j and j+1 (both x and y). Then advance j/p and go to PREP, or to DONE after the last comparison.
- DONE: done=1 and sorted_vld←1 for one cycle, then IDLE.
- Result order: strictly CCW, with cross(P[j]−P0, P[j+1]−P0) > 0 for all neighbours. Collinear and equal-angle pairs swap on every visit (a_bigger=1 at zero). The final order of ties is deterministic but unspecified.
- Reset mid-operation: every state, counter and flag returns to reset value immediately. cp_start drops asynchronously and register-file contents are don't-care.
- Reset values: load_rdy=1; busy, done, sorted_vld, cp_start = 0; cp_* operands = 0.

## Timing
- With the companion unit, cp_cmp rises in the 4th ISSUE cycle. Each comparison therefore takes exactly 6 cycles: PREP 1, ISSUE 4, WB 1.
- After the edge that accepts the last beat, done is high in cycle 6·C+1, which is 61 for N_PT=6.
- ISSUE length is handshake-driven, not counted. A slower unit only stretches ISSUE.
- cp_start is never high on two consecutive comparisons without an intervening low cycle.
- rd_x/rd_y have zero-cycle latency from rd_idx and are meaningful only while sorted_vld=1.

## Configuration
- GEO_SORT_EARLY_EXIT_EN defined: a per-pass swap flag is cleared at pass start. If a pass ends with no swap, go directly to DONE.
- GEO_SORT_EARLY_EXIT_EN undefined: all C comparisons always execute, and latency is fixed at 6·C+1.

## Test plan
- Reset: hold reset=0 for 3 cycles, then release. Required: load_rdy=1, busy=0, done=0, sorted_vld=0, cp_start=0.
- Sorted input: P0..P5 = (500,500),(600,500),(600,600),(500,600),(400,600),(400,500). Macro undefined: 10 comparisons, 0 swaps, done in cycle 61, readback order unchanged.
- Reversed input: P1..P5 = (400,500),(400,600),(500,600),(600,600),(600,500). Required: 10 swaps, done in cycle 61, readback equals the sorted set above.
- Early exit: repeat the sorted input with GEO_SORT_EARLY_EXIT_EN defined. Required: 4 comparisons, done in cycle 25.
- Handshake: hold cp_cmp low for 10 extra cycles on the 3rd comparison. Required: cp_start and operands are stable throughout, and done is delayed by exactly 10 cycles.
- Protocol and reset:
  - Pulse load_vld during busy: the beat is ignored and load_rdy=0.
  - Assert reset in the 2nd ISSUE cycle: cp_start=0 and busy=0 immediately.
  - A fresh load then sorts correctly.
